// File: rtl/permutation_sequencer.sv
// rtl/permutation_sequencer.sv - round sequencer for the permutation datapath (start/done handshake)
// Optional completed-permutation counter on perm_count_o when PERM_CNT_EN is defined.
module permutation_sequencer #(
   parameter int ROUNDS_A = 12,
   parameter int ROUNDS_B = 6,
   parameter int ROUND_W  = 4
) (
   input  logic               clock_i,
   input  logic               resetb_i,
   input  logic               start_i,
   input  logic               mode_i,
   output logic [ROUND_W-1:0] round_o,
   output logic               input_mode_o,
   output logic               enable_o,
   output logic               last_round_o,
   output logic               busy_o,
`ifdef PERM_CNT_EN
   output logic               done_o,
   output logic [15:0]        perm_count_o
`else
   output logic               done_o
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [ROUND_W-1:0] FIRST_A = ROUND_W'(12 - ROUNDS_A);
   localparam logic [ROUND_W-1:0] FIRST_B = ROUND_W'(12 - ROUNDS_B);
   localparam logic [ROUND_W-1:0] LAST    = ROUND_W'(11);

   generate
      if ((ROUNDS_A < 1) || (ROUNDS_A > 12) || (ROUNDS_B < 1) || (ROUNDS_B > 12)) begin : g_bad_rounds
         $error("permutation_sequencer: ROUNDS_A and ROUNDS_B must be in 1..12");
      end
   endgenerate

   state_t             r_state, w_state_nxt;
   logic [ROUND_W-1:0] r_round, w_round_nxt, w_first;
   logic               r_input_mode, w_input_mode_nxt;
   logic               r_enable, w_enable_nxt;
   logic               r_last, w_last_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_done, w_done_nxt;

   assign w_first = mode_i ? FIRST_B : FIRST_A;

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         r_state      <= S_IDLE;
         r_round      <= '0;
         r_input_mode <= 1'b1;
         r_enable     <= 1'b0;
         r_last       <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_round      <= w_round_nxt;
         r_input_mode <= w_input_mode_nxt;
         r_enable     <= w_enable_nxt;
         r_last       <= w_last_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
      end
   end

   // Outputs are registered, so each branch computes the values seen in the following cycle.
   always_comb begin
      w_state_nxt      = r_state;
      w_round_nxt      = r_round;
      w_input_mode_nxt = 1'b1;
      w_enable_nxt     = 1'b0;
      w_last_nxt       = 1'b0;
      w_busy_nxt       = 1'b0;
      w_done_nxt       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_state_nxt  = S_RUN;
               w_round_nxt  = w_first;
               w_enable_nxt = 1'b1;
               w_busy_nxt   = 1'b1;
               w_last_nxt   = (w_first == LAST);
            end
         end
         S_RUN: begin
            if (r_round == LAST) begin
               w_state_nxt = S_DONE;
               w_done_nxt  = 1'b1;
            end else begin
               w_round_nxt      = r_round + 1'b1;
               w_input_mode_nxt = 1'b0;
               w_enable_nxt     = 1'b1;
               w_busy_nxt       = 1'b1;
               w_last_nxt       = ((r_round + 1'b1) == LAST);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

`ifdef PERM_CNT_EN
   logic [15:0] r_perm_count;

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         r_perm_count <= '0;
      end else if ((r_state == S_RUN) && (w_state_nxt == S_DONE) && (r_perm_count != 16'hFFFF)) begin
         r_perm_count <= r_perm_count + 16'd1;
      end
   end

   assign perm_count_o = r_perm_count;
`endif

   assign round_o      = r_round;
   assign input_mode_o = r_input_mode;
   assign enable_o     = r_enable;
   assign last_round_o = r_last;
   assign busy_o       = r_busy;
   assign done_o       = r_done;

endmodule

// File: tb/tb_permutation_sequencer.sv
// tb/tb_permutation_sequencer.sv - bench for permutation_sequencer
// Directed vector table plus random start/mode traffic against a queue-based expected-output model.
module tb_permutation_sequencer;

   localparam int RA = 12;
   localparam int RB = 6;

   typedef struct packed {
      logic [3:0] round;
      logic       im;
      logic       en;
      logic       last;
      logic       busy;
      logic       done;
   } out_t;

   typedef struct {
      logic start;
      logic mode;
      out_t exp;
   } vec_t;

   logic       clk;
   logic       resetb;
   logic       start;
   logic       mode;
   logic [3:0] round_o;
   logic       input_mode_o, enable_o, last_round_o, busy_o, done_o;
`ifdef PERM_CNT_EN
   logic [15:0] perm_count_o;
`endif

   permutation_sequencer #(.ROUNDS_A(RA), .ROUNDS_B(RB), .ROUND_W(4)) dut (
      .clock_i      (clk),
      .resetb_i     (resetb),
      .start_i      (start),
      .mode_i       (mode),
      .round_o      (round_o),
      .input_mode_o (input_mode_o),
      .enable_o     (enable_o),
      .last_round_o (last_round_o),
      .busy_o       (busy_o),
`ifdef PERM_CNT_EN
      .done_o       (done_o),
      .perm_count_o (perm_count_o)
`else
      .done_o       (done_o)
`endif
   );

   out_t act;
   assign act = {round_o, input_mode_o, enable_o, last_round_o, busy_o, done_o};

   localparam out_t RST = {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   int total = 0;
   int bad   = 0;

   out_t        cur;
   out_t        q[$];
   int unsigned exp_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic out_t mk_out(int r, logic im, logic en, logic last, logic busy, logic done);
      out_t o;
      o.round = 4'(r);
      o.im    = im;
      o.en    = en;
      o.last  = last;
      o.busy  = busy;
      o.done  = done;
      return o;
   endfunction

   function automatic vec_t mk_vec(logic s, logic m, out_t e);
      vec_t v;
      v.start = s;
      v.mode  = m;
      v.exp   = e;
      return v;
   endfunction

   task automatic check(input string name, input out_t a, input out_t e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s @%0t: got round=%0d im=%0b en=%0b last=%0b busy=%0b done=%0b, want round=%0d im=%0b en=%0b last=%0b busy=%0b done=%0b",
                  name, $time, a.round, a.im, a.en, a.last, a.busy, a.done,
                  e.round, e.im, e.en, e.last, e.busy, e.done);
      end
   endtask

   task automatic check_int(input string name, input int a, input int e);
      total++;
      if (a != e) begin
         bad++;
         $display("FAIL %s @%0t: got %0d, want %0d", name, $time, a, e);
      end
   endtask

   // Expected outputs: an accepted request expands into its whole output trace up front.
   task automatic model_edge(input logic s, input logic m);
      int n;
      int first;
      if (q.size() != 0) begin
         cur = q.pop_front();
      end else if (s) begin
         n     = m ? RB : RA;
         first = 12 - n;
         for (int k = 0; k < n; k++)
            q.push_back(mk_out(first + k, k == 0, 1'b1, (first + k) == 11, 1'b1, 1'b0));
         q.push_back(mk_out(11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
         q.push_back(mk_out(11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
         cur = q.pop_front();
      end else begin
         cur = mk_out(int'(cur.round), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      if (cur.done && exp_cnt != 32'hFFFF) exp_cnt++;
   endtask

   task automatic step(input logic s, input logic m);
      start = s;
      mode  = m;
      @(posedge clk);
      model_edge(s, m);
      @(negedge clk);
   endtask

   vec_t tbl[10];
   int   low_run;
   logic seen_en;
   logic found;

   initial begin
      tbl[0] = mk_vec(1'b1, 1'b1, mk_out(6,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
      tbl[1] = mk_vec(1'b0, 1'b0, mk_out(7,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
      tbl[2] = mk_vec(1'b0, 1'b1, mk_out(8,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
      tbl[3] = mk_vec(1'b1, 1'b0, mk_out(9,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
      tbl[4] = mk_vec(1'b0, 1'b0, mk_out(10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
      tbl[5] = mk_vec(1'b0, 1'b0, mk_out(11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      tbl[6] = mk_vec(1'b1, 1'b0, mk_out(11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      tbl[7] = mk_vec(1'b1, 1'b0, mk_out(11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      tbl[8] = mk_vec(1'b0, 1'b0, mk_out(11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      tbl[9] = mk_vec(1'b0, 1'b1, mk_out(11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

      resetb = 1'b0;
      start  = 1'b1;
      mode   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("reset_hold", act, RST);
      end
      cur = RST;
      q.delete();
      resetb = 1'b1;

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].start, tbl[i].mode);
         check($sformatf("table_%0d", i), act, tbl[i].exp);
      end

      step(1'b1, 1'b0);
      check("pa_accept", act, cur);
      for (int i = 0; i < 14; i++) begin
         step(1'b0, i[0]);
         check("pa_run", act, cur);
      end

      // Start held high: back-to-back runs, two idle cycles between enable bursts.
      low_run = 0;
      seen_en = 1'b0;
      for (int i = 0; i < 45; i++) begin
         step(1'b1, 1'($urandom));
         check("b2b", act, cur);
         if (act.en) begin
            if (seen_en && low_run > 0) check_int("b2b_gap", low_run, 2);
            low_run = 0;
            seen_en = 1'b1;
         end else if (seen_en) begin
            low_run++;
         end
      end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0);
         check("drain", act, cur);
      end

      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 3) == 0, 1'($urandom));
         check("random", act, cur);
      end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0);
         check("drain2", act, cur);
      end

      step(1'b1, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b0, 1'b0);
         check("pre_abort", act, cur);
         if (act.en && act.round == 4'd5) found = 1'b1;
      end
      check_int("reach_round5", int'(found), 1);
      #2 resetb = 1'b0;
      #1 check("async_abort", act, RST);
      cur = RST;
      q.delete();
      @(posedge clk);
      @(negedge clk);
      check("abort_held", act, RST);
      resetb = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0);
         check("post_abort_idle", act, cur);
      end
      step(1'b1, 1'b0);
      check("restart_accept", act, cur);
      for (int i = 0; i < 14; i++) begin
         step(1'b0, 1'b1);
         check("restart_run", act, cur);
      end

`ifdef PERM_CNT_EN
      check_int("perm_count", int'(perm_count_o), int'(exp_cnt));
      dut.r_perm_count = 16'hFFFE;
      exp_cnt = 32'hFFFE;
      for (int p = 0; p < 3; p++) begin
         step(1'b1, 1'b1);
         for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
      end
      check_int("perm_count_sat", int'(perm_count_o), 16'hFFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
